// File: rtl/pnc_swu_request_queue.sv
// Buffers STDP weight-update requests and issues them one at a time as a single-cycle SWU_EN strobe, issuing 2 edges after a push into an idle, empty queue.
// req_ready = !full; a request seen while full is dropped and latches ovf. `define SWU_COALESCE_EN to merge same-address pushes into the newest entry.
module pnc_swu_request_queue #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_data,
  input  logic                     host_busy,
  input  logic                     pnc_wait,
  output logic                     SWU_EN,
  output logic [ADDR_W-1:0]        SWU_ADDR,
  output logic [DATA_W-1:0]        SWU_DATA,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     newest_idx;
  logic [CW-1:0]     count;
  logic              ovf_q;

  state_t            state_q;
  state_t            state_d;
  logic [GW-1:0]     gap_q;
  logic [GW-1:0]     gap_d;
  logic              en_q;
  logic              en_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  logic full;
  logic empty;
  logic push_ok;
  logic issue_go;
  logic coalesce;
  logic alloc;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign newest_idx = wr_ptr - AW'(1);
  assign push_ok    = req_valid && !full;
  assign issue_go   = (state_q == S_IDLE) && !empty && !host_busy && !pnc_wait;

`ifdef SWU_COALESCE_EN
  // With a single entry being popped this cycle the newest entry is leaving, so allocate instead.
  assign coalesce = push_ok && !empty && (mem_addr[newest_idx] == req_addr)
                    && !(issue_go && (count == CW'(1)));
`else
  assign coalesce = 1'b0;
`endif

  assign alloc = push_ok && !coalesce;

  always_ff @(posedge clk) begin
    if (rst && !flush) begin
      if (alloc) begin
        mem_addr[wr_ptr] <= req_addr;
        mem_data[wr_ptr] <= req_data;
      end else if (coalesce) begin
        mem_data[newest_idx] <= req_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (alloc)
        wr_ptr <= wr_ptr + AW'(1);
      if (issue_go)
        rd_ptr <= rd_ptr + AW'(1);
      case ({alloc, issue_go})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (req_valid && full)
        ovf_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    en_d    = 1'b0;
    addr_d  = '0;
    data_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (issue_go) begin
          state_d = S_ISSUE;
          en_d    = 1'b1;
          addr_d  = mem_addr[rd_ptr];
          data_d  = mem_data[rd_ptr];
        end
      end
      S_ISSUE: begin
        if (GAP_CYCLES == 0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
          gap_d   = GW'(GAP_CYCLES - 1);
        end
      end
      S_GAP: begin
        if (gap_q == '0)
          state_d = S_IDLE;
        else
          gap_d = gap_q - GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign req_ready = !full;
  assign q_count   = count;
  assign ovf       = ovf_q;
  assign SWU_EN    = en_q;
  assign SWU_ADDR  = addr_q;
  assign SWU_DATA  = data_q;

endmodule

// File: tb/tb_pnc_swu_request_queue.sv
// Bench for pnc_swu_request_queue: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_pnc_swu_request_queue;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int GAP    = 1;
  localparam int CW     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              host_busy;
  logic              pnc_wait;
  logic              SWU_EN;
  logic [ADDR_W-1:0] SWU_ADDR;
  logic [DATA_W-1:0] SWU_DATA;
  logic [CW-1:0]     q_count;
  logic              ovf;

  always #5 clk = ~clk;

  pnc_swu_request_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .host_busy(host_busy), .pnc_wait(pnc_wait),
    .SWU_EN(SWU_EN), .SWU_ADDR(SWU_ADDR), .SWU_DATA(SWU_DATA),
    .q_count(q_count), .ovf(ovf)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  // Reference model: a plain queue plus the cycle of the last strobe.
  ent_t              mq[$];
  logic              m_en;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic              m_ovf;
  int                cyc = 0;
  int                last_issue = -1000;

  task automatic model_reset();
    mq.delete();
    m_en = 1'b0; m_addr = '0; m_data = '0; m_ovf = 1'b0;
    last_issue = -1000;
  endtask

  task automatic model_edge();
    bit   issue, full, push, merge;
    ent_t head, e;
    if (!rst || flush) begin
      model_reset();
      cyc++;
      return;
    end
    full  = (mq.size() == DEPTH);
    issue = (cyc >= last_issue + GAP + 1) && (mq.size() > 0) && !host_busy && !pnc_wait;
    head  = issue ? mq[0] : '0;
    push  = req_valid && !full;
    if (req_valid && full) m_ovf = 1'b1;
    merge = 1'b0;
`ifdef SWU_COALESCE_EN
    if (push && mq.size() > 0 && mq[$].a == req_addr && !(issue && mq.size() == 1)) merge = 1'b1;
`endif
    if (issue) void'(mq.pop_front());
    if (merge) begin
      e = mq.pop_back();
      e.d = req_data;
      mq.push_back(e);
    end else if (push) begin
      e.a = req_addr;
      e.d = req_data;
      mq.push_back(e);
    end
    m_en   = issue;
    m_addr = head.a;
    m_data = head.d;
    if (issue) last_issue = cyc + 1;
    cyc++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_valid = 1'b1; req_addr = a; req_data = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
    host_busy = 1'b0; pnc_wait = 1'b0;
    model_reset();
    #3;
    n_vec++;
    if ({SWU_EN, SWU_ADDR, SWU_DATA, ovf, q_count, req_ready} !== {1'b0, 16'h0, 8'h0, 1'b0, 4'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: got en=%b addr=%h data=%h ovf=%b cnt=%0d rdy=%b, expected 0/0/0/0/0/1",
               SWU_EN, SWU_ADDR, SWU_DATA, ovf, q_count, req_ready);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    push_one(16'h1005, 8'h3C);
    n_vec++;
    if (SWU_EN !== 1'b0 || q_count !== 4'd1) begin
      n_err++;
      $display("FAIL single_pre: got en=%b cnt=%0d, expected en=0 cnt=1", SWU_EN, q_count);
    end
    tick();
    n_vec++;
    if (SWU_EN !== 1'b1 || SWU_ADDR !== 16'h1005 || SWU_DATA !== 8'h3C) begin
      n_err++;
      $display("FAIL single_issue: got en=%b addr=%h data=%h, expected 1/1005/3c", SWU_EN, SWU_ADDR, SWU_DATA);
    end
    tick();
    n_vec++;
    if (SWU_EN !== 1'b0 || SWU_ADDR !== 16'h0 || SWU_DATA !== 8'h0 || q_count !== 4'd0) begin
      n_err++;
      $display("FAIL single_post: got en=%b addr=%h data=%h cnt=%0d, expected all 0",
               SWU_EN, SWU_ADDR, SWU_DATA, q_count);
    end
    repeat (3) tick();
  endtask

  task automatic test_fill_overflow();
    logic [DATA_W-1:0] dat [8];
    int n_iss, prev;
    host_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dat[i] = DATA_W'($urandom);
      push_one(16'h3000 + 16'(i), dat[i]);
    end
    n_vec++;
    if (q_count !== 4'd8 || req_ready !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL fill_full: got cnt=%0d rdy=%b ovf=%b, expected 8/0/0", q_count, req_ready, ovf);
    end
    push_one(16'h3FFF, 8'hEE);
    n_vec++;
    if (ovf !== 1'b1 || q_count !== 4'd8) begin
      n_err++;
      $display("FAIL fill_ovf: got ovf=%b cnt=%0d, expected 1/8", ovf, q_count);
    end
    host_busy = 1'b0;
    n_iss = 0; prev = -1;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (SWU_EN === 1'b1) begin
        n_vec++;
        if (n_iss >= 8 || SWU_ADDR !== 16'h3000 + 16'(n_iss) || SWU_DATA !== dat[n_iss]) begin
          n_err++;
          $display("FAIL fill_order[%0d]: got addr=%h data=%h, expected addr=%h", n_iss, SWU_ADDR, SWU_DATA,
                   16'h3000 + 16'(n_iss));
        end
        if (prev >= 0) begin
          n_vec++;
          if (t - prev != GAP + 2) begin
            n_err++;
            $display("FAIL fill_spacing: got %0d cycles between strobes, expected %0d", t - prev, GAP + 2);
          end
        end
        prev = t;
        n_iss++;
      end
    end
    n_vec++;
    if (n_iss != 8) begin
      n_err++;
      $display("FAIL fill_issue_count: got %0d issues, expected 8", n_iss);
    end
  endtask

  task automatic test_pnc_wait();
    int seen;
    pnc_wait = 1'b1;
    for (int i = 0; i < 3; i++) push_one(16'h4000 + 16'(i), 8'(8'h40 + i));
    seen = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (SWU_EN === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0 || q_count !== 4'd3) begin
      n_err++;
      $display("FAIL wait_block: got %0d strobes cnt=%0d, expected 0 strobes cnt=3", seen, q_count);
    end
    pnc_wait = 1'b0;
    tick();
    n_vec++;
    if (SWU_EN !== 1'b1 || SWU_ADDR !== 16'h4000 || SWU_DATA !== 8'h40) begin
      n_err++;
      $display("FAIL wait_resume: got en=%b addr=%h data=%h, expected 1/4000/40", SWU_EN, SWU_ADDR, SWU_DATA);
    end
    repeat (10) tick();
  endtask

  task automatic test_flush();
    int seen;
    host_busy = 1'b1;
    for (int i = 0; i < 4; i++) push_one(16'h5000 + 16'(i), 8'(i));
    host_busy = 1'b0;
    for (int t = 0; t < 5 && SWU_EN !== 1'b1; t++) tick();
    n_vec++;
    if (SWU_EN !== 1'b1) begin
      n_err++;
      $display("FAIL flush_wait_issue: got en=%b after 5 cycles, expected 1", SWU_EN);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++;
    if (SWU_EN !== 1'b0 || q_count !== 4'd0 || ovf !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_clear: got en=%b cnt=%0d ovf=%b rdy=%b, expected 0/0/0/1", SWU_EN, q_count, ovf, req_ready);
    end
    seen = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (SWU_EN === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL flush_quiet: got %0d strobes, expected 0", seen);
    end
  endtask

  task automatic test_async_reset();
    int seen;
    host_busy = 1'b1;
    for (int i = 0; i < 3; i++) push_one(16'h6000 + 16'(i), 8'(8'h60 + i));
    host_busy = 1'b0;
    for (int t = 0; t < 5 && SWU_EN !== 1'b1; t++) tick();
    tick();
    n_vec++;
    if (q_count !== 4'd2 || SWU_EN !== 1'b0) begin
      n_err++;
      $display("FAIL areset_pre: got cnt=%0d en=%b, expected 2/0", q_count, SWU_EN);
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({SWU_EN, SWU_ADDR, SWU_DATA, ovf, q_count, req_ready} !== {1'b0, 16'h0, 8'h0, 1'b0, 4'd0, 1'b1}) begin
      n_err++;
      $display("FAIL areset_immediate: got en=%b addr=%h data=%h ovf=%b cnt=%0d rdy=%b, expected 0/0/0/0/0/1",
               SWU_EN, SWU_ADDR, SWU_DATA, ovf, q_count, req_ready);
    end
    tick();
    rst = 1'b1;
    seen = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (SWU_EN === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL areset_quiet: got %0d strobes, expected 0", seen);
    end
  endtask

`ifdef SWU_COALESCE_EN
  task automatic test_coalesce();
    int seen;
    logic [DATA_W-1:0] last_d;
    host_busy = 1'b1;
    push_one(16'h2001, 8'h10);
    push_one(16'h2001, 8'h22);
    n_vec++;
    if (q_count !== 4'd1) begin
      n_err++;
      $display("FAIL coalesce_count: got cnt=%0d, expected 1", q_count);
    end
    host_busy = 1'b0;
    seen = 0; last_d = '0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (SWU_EN === 1'b1) begin
        seen++;
        last_d = SWU_DATA;
      end
    end
    n_vec++;
    if (seen != 1 || last_d !== 8'h22) begin
      n_err++;
      $display("FAIL coalesce_issue: got %0d strobes data=%h, expected 1 strobe data=22", seen, last_d);
    end
  endtask
`endif

  task automatic test_random();
    for (int t = 0; t < 3000; t++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      req_addr  = 16'h7000 + 16'($urandom_range(0, 3));
      req_data  = DATA_W'($urandom);
      host_busy = ($urandom_range(0, 3) == 0);
      pnc_wait  = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 99) == 0);
      tick();
      n_vec++;
      if (SWU_EN !== m_en || SWU_ADDR !== m_addr || SWU_DATA !== m_data || q_count !== CW'(mq.size())
          || ovf !== m_ovf || req_ready !== (mq.size() != DEPTH)) begin
        n_err++;
        $display("FAIL random[%0d]: got en=%b addr=%h data=%h cnt=%0d ovf=%b rdy=%b, expected en=%b addr=%h data=%h cnt=%0d ovf=%b rdy=%b",
                 t, SWU_EN, SWU_ADDR, SWU_DATA, q_count, ovf, req_ready,
                 m_en, m_addr, m_data, mq.size(), m_ovf, (mq.size() != DEPTH));
      end
    end
    req_valid = 1'b0; host_busy = 1'b0; pnc_wait = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_pnc_wait();
    test_flush();
    test_async_reset();
`ifdef SWU_COALESCE_EN
    test_coalesce();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
